trace_nop_event_unit: RTL and testbench

- Consumes the per-core mor1kx execution trace that the compute tile exports; one instance per core, downstream of the tile trace port.
- Shadows r3 and decodes simulation-control l.nop instructions (EXIT, REPORT, PUTC).
- Queues the resulting events in a small FIFO behind a valid/ready interface for a debug/STM-style consumer.
- Tracks termination and the exit code in synthesizable logic, so hardware and simulation share one event source.

---
 rtl/trace_nop_event_unit_if.sv | 31 +++
 rtl/trace_nop_event_unit.sv | 179 +++++++++++++++++
 tb/tb_trace_nop_event_unit.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_nop_event_unit_if.sv
// Trace-in / event-out bus for trace_nop_event_unit.
// The slave modport is the event unit's view: it consumes the retired-instruction
// trace and produces events. The master modport is the trace source / event consumer.
interface trace_nop_event_unit_if;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_insn;
  logic        trace_wben;
  logic [4:0]  trace_wbreg;
  logic [31:0] trace_wbdata;

  logic        evt_valid;
  logic        evt_ready;
  logic [1:0]  evt_type;
  logic [31:0] evt_data;
  logic [31:0] evt_pc;
  logic [31:0] evt_time;
  logic [15:0] evt_core;

  modport slave (
    input  trace_valid, trace_pc, trace_insn, trace_wben, trace_wbreg, trace_wbdata,
    input  evt_ready,
    output evt_valid, evt_type, evt_data, evt_pc, evt_time, evt_core
  );

  modport master (
    output trace_valid, trace_pc, trace_insn, trace_wben, trace_wbreg, trace_wbdata,
    output evt_ready,
    input  evt_valid, evt_type, evt_data, evt_pc, evt_time, evt_core
  );
endinterface

// File: rtl/trace_nop_event_unit.sv
// trace_nop_event_unit: shadows r3 from the mor1kx execution trace, decodes the
// simulation-control l.nop instructions (EXIT, REPORT, PUTC) and queues them in a
// show-ahead FIFO behind a valid/ready event port. Tracks termination and exit code.
// Optional feature macro: TRACE_NOP_TIMESTAMP_EN adds a free-running cycle counter
// whose decode-cycle value is stored with every event and presented on evt_time.
module trace_nop_event_unit #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CORE_ID    = 0,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  trace_nop_event_unit_if.slave bus,
  output logic [31:0]           r3,
  output logic                  terminated,
  output logic [31:0]           exit_code,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    EV_EXIT   = 2'd0,
    EV_REPORT = 2'd1,
    EV_PUTC   = 2'd2
  } ev_type_e;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_e;

  state_e      state, next_state;

  logic        dec_hit;
  ev_type_e    dec_type;
  logic [31:0] dec_data;
  logic        push_req;
  logic        exit_fire;

  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;
  logic        pop, push_ok, drop;

  logic [1:0]  type_mem [FIFO_DEPTH];
  logic [31:0] data_mem [FIFO_DEPTH];
  logic [31:0] pc_mem   [FIFO_DEPTH];

  // Instruction bits 23:16 of an l.nop carry no meaning for event decode.
  logic unused_insn_bits;
  assign unused_insn_bits = ^bus.trace_insn[23:16];

  // Decode simulation-control l.nop; the captured value is the registered r3.
  always_comb begin
    dec_hit  = 1'b0;
    dec_type = EV_REPORT;
    if (bus.trace_valid && bus.trace_insn[31:24] == 8'h15) begin
      case (bus.trace_insn[15:0])
        16'h0001: begin dec_hit = 1'b1; dec_type = EV_EXIT;   end
        16'h0002: begin dec_hit = 1'b1; dec_type = EV_REPORT; end
        16'h0004: begin dec_hit = 1'b1; dec_type = EV_PUTC;   end
        default:  begin dec_hit = 1'b0; dec_type = EV_REPORT; end
      endcase
    end
    dec_data = (dec_type == EV_PUTC) ? {24'h0, r3[7:0]} : r3;
  end

  // Termination state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= next_state;
  end

  // RUN forwards decodes to the FIFO; DONE swallows everything until reset.
  always_comb begin
    next_state = state;
    push_req   = 1'b0;
    exit_fire  = 1'b0;
    case (state)
      RUN: begin
        if (dec_hit) begin
          push_req = 1'b1;
          if (dec_type == EV_EXIT) begin
            exit_fire  = 1'b1;
            next_state = DONE;
          end
        end
      end
      DONE:    next_state = DONE;
      default: next_state = RUN;
    endcase
  end

  assign terminated = (state == DONE);

  // Shadow r3 from retired write-backs.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r3 <= '0;
    else if (bus.trace_valid && bus.trace_wben && bus.trace_wbreg == 5'd3)
      r3 <= bus.trace_wbdata;
  end

  // Latch r3 as the exit code on the EXIT edge.
  always_ff @(posedge clk) begin
    if (!rst_n)         exit_code <= '0;
    else if (exit_fire) exit_code <= r3;
  end

  // FIFO status from pointer compare; a pop frees the slot for a same-cycle push.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !fifo_empty && bus.evt_ready;
  assign push_ok    = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  // FIFO pointers and saturating drop counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      drop_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (drop && drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end

  // Event storage; contents are only observed between valid pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      type_mem[wr_ptr[AW-1:0]] <= dec_type;
      data_mem[wr_ptr[AW-1:0]] <= dec_data;
      pc_mem[wr_ptr[AW-1:0]]   <= bus.trace_pc;
    end
  end

`ifdef TRACE_NOP_TIMESTAMP_EN
  logic [31:0] timestamp;
  logic [31:0] time_mem [FIFO_DEPTH];

  // Free-running cycle counter, zero in the first cycle after reset release.
  always_ff @(posedge clk) begin
    if (!rst_n) timestamp <= '0;
    else        timestamp <= timestamp + 32'd1;
  end

  // Timestamp storage alongside the event entry.
  always_ff @(posedge clk) begin
    if (push_ok) time_mem[wr_ptr[AW-1:0]] <= timestamp;
  end

  // Head timestamp, forced to zero when no event is presented.
  always_comb begin
    bus.evt_time = '0;
    if (!fifo_empty) bus.evt_time = time_mem[rd_ptr[AW-1:0]];
  end
`else
  assign bus.evt_time = '0;
`endif

  assign bus.evt_valid = !fifo_empty;

  // Show-ahead head presentation; all event fields read zero while empty.
  always_comb begin
    bus.evt_type = '0;
    bus.evt_data = '0;
    bus.evt_pc   = '0;
    bus.evt_core = '0;
    if (!fifo_empty) begin
      bus.evt_type = type_mem[rd_ptr[AW-1:0]];
      bus.evt_data = data_mem[rd_ptr[AW-1:0]];
      bus.evt_pc   = pc_mem[rd_ptr[AW-1:0]];
      bus.evt_core = 16'(CORE_ID);
    end
  end

endmodule

// File: tb/tb_trace_nop_event_unit.sv
// Randomized self-checking bench for trace_nop_event_unit with a queue-based
// reference model and a few directed scenarios with literal expectations.
module tb_trace_nop_event_unit;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CORE   = 5;
  localparam int unsigned DW     = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   r3;
  logic          terminated;
  logic [31:0]   exit_code;
  logic [DW-1:0] drop_count;

  trace_nop_event_unit_if bus_if ();

  trace_nop_event_unit #(
    .FIFO_DEPTH (DEPTH),
    .CORE_ID    (CORE),
    .DROP_CNT_W (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus_if),
    .r3         (r3),
    .terminated (terminated),
    .exit_code  (exit_code),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  typ;
    logic [31:0] data;
    logic [31:0] pc;
    logic [31:0] tim;
  } ev_t;

  ev_t         q[$];
  logic [31:0] m_r3;
  logic        m_term;
  logic [31:0] m_exit;
  int unsigned m_drop;
  logic [31:0] m_ts;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference behaviour for one clock edge, from the current inputs and model state.
  task automatic model_step();
    logic  pop, hit;
    ev_t   e;
    if (!rst_n) begin
      q.delete();
      m_r3 = 0; m_term = 0; m_exit = 0; m_drop = 0; m_ts = 0;
      return;
    end
    pop = (q.size() > 0) && bus_if.evt_ready;
    hit = 1'b0;
    e.typ = 0;
    if (bus_if.trace_valid && bus_if.trace_insn[31:24] == 8'h15 && !m_term) begin
      case (bus_if.trace_insn[15:0])
        16'h0001: begin hit = 1; e.typ = 0; end
        16'h0002: begin hit = 1; e.typ = 1; end
        16'h0004: begin hit = 1; e.typ = 2; end
        default:  hit = 0;
      endcase
    end
    e.data = (e.typ == 2) ? (m_r3 & 32'hFF) : m_r3;
    e.pc   = bus_if.trace_pc;
`ifdef TRACE_NOP_TIMESTAMP_EN
    e.tim  = m_ts;
`else
    e.tim  = 0;
`endif
    if (pop) void'(q.pop_front());
    if (hit) begin
      if (q.size() < DEPTH) q.push_back(e);
      else if (m_drop < (1 << DW) - 1) m_drop++;
      if (e.typ == 0) begin
        m_term = 1;
        m_exit = m_r3;
      end
    end
    if (bus_if.trace_valid && bus_if.trace_wben && bus_if.trace_wbreg == 5'd3)
      m_r3 = bus_if.trace_wbdata;
    m_ts = m_ts + 1;
  endtask

  // Compare every DUT output against the model, away from the active edge.
  always @(negedge clk) begin
    check("evt_valid", 64'(bus_if.evt_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      check("evt_type", 64'(bus_if.evt_type), 64'(q[0].typ));
      check("evt_data", 64'(bus_if.evt_data), 64'(q[0].data));
      check("evt_pc",   64'(bus_if.evt_pc),   64'(q[0].pc));
      check("evt_time", 64'(bus_if.evt_time), 64'(q[0].tim));
      check("evt_core", 64'(bus_if.evt_core), 64'(CORE));
    end else begin
      check("evt_type_idle", 64'(bus_if.evt_type), 64'd0);
      check("evt_data_idle", 64'(bus_if.evt_data), 64'd0);
      check("evt_pc_idle",   64'(bus_if.evt_pc),   64'd0);
      check("evt_time_idle", 64'(bus_if.evt_time), 64'd0);
    end
    check("r3",         64'(r3),         64'(m_r3));
    check("terminated", 64'(terminated), 64'(m_term));
    check("exit_code",  64'(exit_code),  64'(m_exit));
    check("drop_count", 64'(drop_count), 64'(m_drop));
  end

  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                      input logic wben, input logic [4:0] wreg, input logic [31:0] wdata,
                      input logic rdy);
    bus_if.trace_valid  = v;
    bus_if.trace_pc     = pc;
    bus_if.trace_insn   = insn;
    bus_if.trace_wben   = wben;
    bus_if.trace_wbreg  = wreg;
    bus_if.trace_wbdata = wdata;
    bus_if.evt_ready    = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, rdy);
  endtask

  task automatic nop(input logic [15:0] k, input logic [31:0] pc, input logic rdy);
    step(1'b1, pc, {16'h1500, k}, 1'b0, 5'd0, 32'h0, rdy);
  endtask

  task automatic wr_r3(input logic [31:0] val, input logic rdy);
    step(1'b1, 32'h80, 32'hE0630000, 1'b1, 5'd3, val, rdy);
  endtask

  initial begin
    logic [15:0] ks [8];
    logic [31:0] insn;
    int unsigned sel;
    logic        rdy;
    int unsigned rdy_mode;
    ks = '{16'h0001, 16'h0002, 16'h0004, 16'h0000, 16'h0003, 16'h0005, 16'hFFFF, 16'h0002};

    // Reset state
    rst_n = 1'b0;
    idle(1'b1);
    idle(1'b1);
    check("rst_evt_valid", 64'(bus_if.evt_valid), 64'd0);
    check("rst_r3",        64'(r3),               64'd0);
    check("rst_drop",      64'(drop_count),       64'd0);
    check("rst_term",      64'(terminated),       64'd0);
    rst_n = 1'b1;

    // REPORT in cycle 5 after reset release
    for (int i = 0; i < 5; i++) idle(1'b1);
    nop(16'h0002, 32'h100, 1'b1);
    check("rep_valid", 64'(bus_if.evt_valid), 64'd1);
    check("rep_type",  64'(bus_if.evt_type),  64'd1);
`ifdef TRACE_NOP_TIMESTAMP_EN
    check("rep_time",  64'(bus_if.evt_time),  64'd5);
`else
    check("rep_time",  64'(bus_if.evt_time),  64'd0);
`endif
    idle(1'b1);

    // PUTC after an r3 write
    wr_r3(32'h41, 1'b1);
    nop(16'h0004, 32'h200, 1'b1);
    check("putc_data", 64'(bus_if.evt_data), 64'h41);
    check("putc_type", 64'(bus_if.evt_type), 64'd2);
    check("putc_pc",   64'(bus_if.evt_pc),   64'h200);
    idle(1'b1);

    // Same-cycle r3 write is not forwarded
    step(1'b1, 32'h204, 32'h15000002, 1'b1, 5'd3, 32'h99, 1'b1);
    check("fwd_data", 64'(bus_if.evt_data), 64'h41);
    check("fwd_r3",   64'(r3),              64'h99);
    idle(1'b1);

    // Overfill with consumer stalled
    for (int i = 0; i < 10; i++) nop(16'h0002, 32'h300 + 32'(4 * i), 1'b0);
    check("full_drop", 64'(drop_count),    64'd2);
    check("full_head", 64'(bus_if.evt_pc), 64'h300);
    // Full with a same-cycle pop: push accepted
    nop(16'h0002, 32'h400, 1'b1);
    check("fullpop_drop", 64'(drop_count),    64'd2);
    check("fullpop_head", 64'(bus_if.evt_pc), 64'h304);
    for (int j = 0; j < 8; j++) begin
      check("drain_pc", 64'(bus_if.evt_pc), (j < 7) ? 64'(32'h304 + 32'(4 * j)) : 64'h400);
      idle(1'b1);
    end
    check("drain_empty", 64'(bus_if.evt_valid), 64'd0);

    // Randomized traffic with occasional resets and rare EXITs
    rdy_mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) rdy_mode = $urandom_range(0, 2);
      rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 399) != 0);
      sel = $urandom_range(0, 9);
      if (sel < 6) begin
        insn = {8'h15, 8'($urandom), ks[$urandom_range(1, 7)]};
        if (insn[15:0] == 16'h0001 && $urandom_range(0, 9) != 0) insn[15:0] = 16'h0002;
      end else if (sel == 6 && $urandom_range(0, 29) == 0) begin
        insn = 32'h15000001;
      end else begin
        insn = {8'h9C, 24'($urandom)};
      end
      step(1'($urandom_range(0, 3) != 0), $urandom, insn, 1'($urandom),
           ($urandom_range(0, 1) == 1) ? 5'd3 : 5'($urandom), $urandom, rdy);
    end
    rst_n = 1'b1;

    // EXIT, then further decodes are ignored
    rst_n = 1'b0;
    idle(1'b1);
    rst_n = 1'b1;
    wr_r3(32'h2A, 1'b0);
    nop(16'h0001, 32'h500, 1'b0);
    check("exit_term", 64'(terminated),       64'd1);
    check("exit_code", 64'(exit_code),        64'h2A);
    check("exit_type", 64'(bus_if.evt_type),  64'd0);
    check("exit_data", 64'(bus_if.evt_data),  64'h2A);
    nop(16'h0002, 32'h504, 1'b0);
    check("post_exit_drop", 64'(drop_count),    64'd0);
    check("post_exit_head", 64'(bus_if.evt_pc), 64'h500);
    idle(1'b1);
    check("post_exit_empty", 64'(bus_if.evt_valid), 64'd0);

    // Reset mid-operation discards pending events
    rst_n = 1'b0;
    idle(1'b1);
    rst_n = 1'b1;
    wr_r3(32'h1234, 1'b0);
    nop(16'h0002, 32'h600, 1'b0);
    nop(16'h0004, 32'h604, 1'b0);
    nop(16'h0001, 32'h608, 1'b0);
    rst_n = 1'b0;
    idle(1'b0);
    check("midrst_valid", 64'(bus_if.evt_valid), 64'd0);
    check("midrst_drop",  64'(drop_count),       64'd0);
    check("midrst_term",  64'(terminated),       64'd0);
    check("midrst_r3",    64'(r3),               64'd0);
    rst_n = 1'b1;
    idle(1'b1);
    idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
